fp_mul_arb: RTL and testbench

FP_MUL_ARB -- requirements
Module: fp_mul_arb

---
 rtl/fp_mul_arb.sv | 126 ++++++++++++
 tb/tb_fp_mul_arb.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_arb.sv
// Round-robin arbiter that lets NREQ requesters share one pipelined fp_mul.
// A tag pipeline tracks each issued op so the result is steered back to its owner.
module fp_mul_arb #(
    parameter int NREQ    = 4,
    parameter int LATENCY = 5
) (
    input  logic                 clk,
    input  logic                 areset,
    input  logic                 hold,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic [31:0]          mul_a,
    output logic [31:0]          mul_b,
    input  logic [31:0]          mul_q,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [31:0]          rsp_q,
    output logic [4:0]           inflight,
    output logic                 busy
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef struct packed {
        logic            valid;
        logic [IDXW-1:0] idx;
    } tag_t;

    logic [IDXW-1:0] rr_ptr_q, rr_ptr_d;
    logic [31:0]     mul_a_q, mul_a_d;
    logic [31:0]     mul_b_q, mul_b_d;
    tag_t            issue_q, issue_d;
    tag_t            tag_q [LATENCY];
    tag_t            tag_d [LATENCY];
    logic [4:0]      inflight_q, inflight_d;

    logic            grant_found;
    logic [IDXW-1:0] grant_idx;
    logic [NREQ-1:0] grant;
    logic [IDXW:0]   cand_sum;
    logic [IDXW-1:0] cand_idx;
    tag_t            tag_out;

    // Search starts at rr_ptr and wraps once; rr_ptr < NREQ so one subtraction suffices.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_found = 1'b0;
        cand_sum    = '0;
        cand_idx    = '0;
        if (areset && !hold) begin
            for (int k = 0; k < NREQ; k++) begin
                cand_sum = {1'b0, rr_ptr_q} + (IDXW+1)'(k);
                if (cand_sum >= (IDXW+1)'(NREQ)) begin
                    cand_sum = cand_sum - (IDXW+1)'(NREQ);
                end
                cand_idx = cand_sum[IDXW-1:0];
                if (!grant_found && req_valid[cand_idx]) begin
                    grant_found     = 1'b1;
                    grant_idx       = cand_idx;
                    grant[cand_idx] = 1'b1;
                end
            end
        end
    end

    assign tag_out = tag_q[LATENCY-1];

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        mul_a_d  = mul_a_q;
        mul_b_d  = mul_b_q;
        issue_d  = '{valid: grant_found, idx: grant_idx};
        if (grant_found) begin
            rr_ptr_d = (grant_idx == IDXW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
            mul_a_d  = req_a[32*grant_idx +: 32];
            mul_b_d  = req_b[32*grant_idx +: 32];
        end
        // issue_q lines up with mul_a/mul_b; the last tag stage lines up with mul_q.
        tag_d[0] = issue_q;
        for (int s = 1; s < LATENCY; s++) begin
            tag_d[s] = tag_q[s-1];
        end
        inflight_d = inflight_q + {4'b0, grant_found} - {4'b0, tag_out.valid};
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!areset) begin
            rr_ptr_q   <= '0;
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            issue_q    <= '0;
            inflight_q <= '0;
            // NOTE: the tag array must be reset; a stale valid bit would emit a phantom response.
            for (int s = 0; s < LATENCY; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            mul_a_q    <= mul_a_d;
            mul_b_q    <= mul_b_d;
            issue_q    <= issue_d;
            inflight_q <= inflight_d;
            tag_q      <= tag_d;
        end
    end

    always_comb begin
        rsp_valid = '0;
        rsp_q     = '0;
        if (tag_out.valid) begin
            rsp_valid[tag_out.idx] = 1'b1;
            rsp_q                  = mul_q;
        end
    end

    assign req_ready = grant;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign inflight  = inflight_q;
    assign busy      = (inflight_q != 5'd0);

endmodule

// File: tb/tb_fp_mul_arb.sv
// Directed bench for fp_mul_arb with a table-driven fp_mul stand-in of fixed latency.
module tb_fp_mul_arb;

    localparam int NREQ = 4;
    localparam int L    = 5;

    logic              clk;
    logic              areset;
    logic              hold;
    logic [NREQ-1:0]   req_valid;
    logic [32*NREQ-1:0] req_a;
    logic [32*NREQ-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic [31:0]       mul_a;
    logic [31:0]       mul_b;
    logic [31:0]       mul_q;
    logic [NREQ-1:0]   rsp_valid;
    logic [31:0]       rsp_q;
    logic [4:0]        inflight;
    logic              busy;

    int checks   = 0;
    int failures = 0;

    fp_mul_arb #(.NREQ(NREQ), .LATENCY(L)) dut (
        .clk       (clk),
        .areset    (areset),
        .hold      (hold),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_q     (mul_q),
        .rsp_valid (rsp_valid),
        .rsp_q     (rsp_q),
        .inflight  (inflight),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hand-computed IEEE-754 single products for the operand pairs used below.
    function automatic logic [31:0] fp_ref(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h40000000, 32'h40400000}: fp_ref = 32'h40C00000;  //  2.0 * 3.0
            {32'h3F800000, 32'h3F800000}: fp_ref = 32'h3F800000;  //  1.0 * 1.0
            {32'hC0000000, 32'h40400000}: fp_ref = 32'hC0C00000;  // -2.0 * 3.0
            {32'h3FC00000, 32'h40000000}: fp_ref = 32'h40400000;  //  1.5 * 2.0
            {32'h41200000, 32'h40A00000}: fp_ref = 32'h42480000;  // 10.0 * 5.0
            default:                      fp_ref = 32'h00000000;
        endcase
    endfunction

    logic [31:0] pipe [L];
    always @(posedge clk) begin
        pipe[0] <= fp_ref(mul_a, mul_b);
        for (int s = 1; s < L; s++) pipe[s] <= pipe[s-1];
    end
    assign mul_q = pipe[L-1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
    endtask

    int exp_inf;
    int exp_ret;
    int exp_k;

    initial begin
        areset    = 1'b0;
        hold      = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;

        // Reset state
        tick();
        tick();
        req_valid = 4'hF;
        #1;
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_q", rsp_q, 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_inflight", 32'(inflight), 32'h0);
        check("rst_mul_a", mul_a, 32'h0);
        check("rst_mul_b", mul_b, 32'h0);
        req_valid = '0;
        areset    = 1'b1;
        tick();

        // Single op from requester 0
        set_op(0, 32'h40000000, 32'h40400000);
        req_valid = 4'b0001;
        #1;
        check("single_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        check("single_mul_a", mul_a, 32'h40000000);
        check("single_mul_b", mul_b, 32'h40400000);
        check("single_inflight1", 32'(inflight), 32'd1);
        check("single_busy1", 32'(busy), 32'd1);
        for (int i = 1; i < L; i++) begin
            tick();
            check("single_early_rsp", 32'(rsp_valid), 32'h0);
        end
        tick();
        check("single_rsp_valid", 32'(rsp_valid), 32'b0001);
        check("single_rsp_q", rsp_q, 32'h40C00000);
        check("single_inflight_at_rsp", 32'(inflight), 32'd1);
        tick();
        check("single_rsp_clear", 32'(rsp_valid), 32'h0);
        check("single_rsp_q_zero", rsp_q, 32'h0);
        check("single_inflight0", 32'(inflight), 32'd0);
        check("single_busy0", 32'(busy), 32'd0);

        // Sparse requests: req 2 with rr_ptr=1, then req 0 via wrap
        set_op(2, 32'h3F800000, 32'h3F800000);
        req_valid = 4'b0100;
        #1;
        check("sparse_ready2", 32'(req_ready), 32'b0100);
        tick();
        set_op(0, 32'h40000000, 32'h40400000);
        set_op(3, 32'h3F800000, 32'h3F800000);
        req_valid = 4'b1001;
        #1;
        check("sparse_ptr3", 32'(req_ready), 32'b1000);
        req_valid = 4'b0001;
        #1;
        check("sparse_wrap0", 32'(req_ready), 32'b0001);
        tick();
        req_valid = '0;
        check("sparse_inflight2", 32'(inflight), 32'd2);
        check("sparse_mul_a", mul_a, 32'h40000000);
        repeat (L-1) tick();
        check("sparse_rsp2_valid", 32'(rsp_valid), 32'b0100);
        check("sparse_rsp2_q", rsp_q, 32'h3F800000);
        tick();
        check("sparse_rsp0_valid", 32'(rsp_valid), 32'b0001);
        check("sparse_rsp0_q", rsp_q, 32'h40C00000);
        tick();
        check("sparse_idle", 32'(rsp_valid), 32'h0);
        check("sparse_inflight0", 32'(inflight), 32'd0);

        // Back-to-back ops from requester 1 (rr_ptr=1)
        set_op(1, 32'h3FC00000, 32'h40000000);
        req_valid = 4'b0010;
        #1;
        check("b2b_ready_first", 32'(req_ready), 32'b0010);
        tick();
        set_op(1, 32'h41200000, 32'h40A00000);
        #1;
        check("b2b_ready_second", 32'(req_ready), 32'b0010);
        tick();
        req_valid = '0;
        repeat (L-1) tick();
        check("b2b_rsp1_valid", 32'(rsp_valid), 32'b0010);
        check("b2b_rsp1_q", rsp_q, 32'h40400000);
        tick();
        check("b2b_rsp2_valid", 32'(rsp_valid), 32'b0010);
        check("b2b_rsp2_q", rsp_q, 32'h42480000);
        tick();
        check("b2b_idle_valid", 32'(rsp_valid), 32'h0);
        check("b2b_idle_q", rsp_q, 32'h0);
        check("b2b_inflight0", 32'(inflight), 32'd0);

        // Hold with requester 3 valid; an op issued just before still returns on schedule
        set_op(3, 32'h40000000, 32'h40400000);
        req_valid = 4'b1000;
        #1;
        check("hold_pre_ready", 32'(req_ready), 32'b1000);
        tick();
        hold = 1'b1;
        set_op(3, 32'h3F800000, 32'h3F800000);
        for (int i = 1; i <= 10; i++) begin
            #1;
            check("hold_ready", 32'(req_ready), 32'h0);
            if (i == L + 1) begin
                check("hold_rsp_valid", 32'(rsp_valid), 32'b1000);
                check("hold_rsp_q", rsp_q, 32'h40C00000);
                check("hold_busy_at_rsp", 32'(busy), 32'd1);
            end
            if (i == L + 2) begin
                check("hold_busy_fall", 32'(busy), 32'd0);
                check("hold_inflight0", 32'(inflight), 32'd0);
            end
            tick();
        end
        check("hold_no_issue_mul_a", mul_a, 32'h40000000);
        check("hold_inflight_end", 32'(inflight), 32'd0);
        hold      = 1'b0;
        req_valid = '0;

        // Reset two cycles after an issue (rr_ptr=0, grant 1 moves it to 2)
        set_op(1, 32'h3F800000, 32'h3F800000);
        req_valid = 4'b0010;
        #1;
        check("rstmid_ready", 32'(req_ready), 32'b0010);
        tick();
        req_valid = '0;
        tick();
        areset    = 1'b0;
        req_valid = 4'b1010;
        #1;
        check("rstmid_ready_in_reset", 32'(req_ready), 32'h0);
        tick();
        tick();
        check("rstmid_inflight", 32'(inflight), 32'd0);
        check("rstmid_mul_a", mul_a, 32'h0);
        check("rstmid_rsp_valid", 32'(rsp_valid), 32'h0);
        areset = 1'b1;
        set_op(0, 32'h3F800000, 32'h3F800000);
        set_op(1, 32'h3F800000, 32'h3F800000);
        set_op(2, 32'hC0000000, 32'h40400000);
        set_op(3, 32'h3F800000, 32'h3F800000);
        #1;
        check("rstmid_ptr0", 32'(req_ready), 32'b0010);

        // All four continuously valid for 12 cycles, then drain
        for (int j = 0; j <= 18; j++) begin
            req_valid = (j < 12) ? 4'hF : 4'h0;
            #1;
            check("stream_ready", 32'(req_ready), (j < 12) ? (32'h1 << (j % 4)) : 32'h0);
            exp_ret = j - L - 1;
            if (exp_ret < 0)  exp_ret = 0;
            if (exp_ret > 12) exp_ret = 12;
            exp_inf = ((j < 12) ? j : 12) - exp_ret;
            check("stream_inflight", 32'(inflight), 32'(exp_inf));
            check("stream_busy", 32'(busy), (exp_inf != 0) ? 32'd1 : 32'd0);
            exp_k = j - L - 1;
            if (exp_k >= 0 && exp_k < 12) begin
                check("stream_rsp_valid", 32'(rsp_valid), 32'h1 << (exp_k % 4));
                check("stream_rsp_q", rsp_q, ((exp_k % 4) == 2) ? 32'hC0C00000 : 32'h3F800000);
            end else begin
                check("stream_no_rsp", 32'(rsp_valid), 32'h0);
                check("stream_rsp_q_zero", rsp_q, 32'h0);
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
